// File: rtl/canny_pkg.sv
// Shared definitions for the Canny threshold controller: FSM encoding,
// config register map and reset defaults.
package canny_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [1:0] CFG_THRESH = 2'd0;
    localparam logic [1:0] CFG_TARGET = 2'd1;
    localparam logic [1:0] CFG_AUTO   = 2'd2;
    localparam logic [1:0] CFG_RSVD   = 2'd3;

    localparam int DEF_TH_HIGH = 100;
    localparam int DEF_TH_LOW  = 50;
    localparam int DEF_TH_MIN  = 16;
    localparam int DEF_TARGET  = 4000;
    localparam int DEF_STEP    = 4;

    localparam int EDGE_W = 17;

endpackage

// File: rtl/canny_edge_counter.sv
// Saturating per-frame edge-pixel counter; clear has priority over inc.
module canny_edge_counter #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && count != '1)
            count <= count + W'(1);
    end

endmodule

// File: rtl/canny_threshold_ctrl.sv
// Frame-synchronous Canny threshold controller: counts edge pixels per frame and
// retunes the hysteresis thresholds (manual or auto) one cycle after each boundary.
module canny_threshold_ctrl
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH    = 320,
    parameter int IMG_HEIGHT   = 240,
    parameter int TH_HIGH_INIT = DEF_TH_HIGH,
    parameter int TH_LOW_INIT  = DEF_TH_LOW,
    parameter int TH_MIN       = DEF_TH_MIN,
    parameter int TARGET_INIT  = DEF_TARGET,
    parameter int STEP_INIT    = DEF_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              canny_ready,
    input  logic [7:0]        canny_pixel,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [15:0]       cfg_wdata,
    output logic              canny_enable,
    output logic [7:0]        threshold_low,
    output logic [7:0]        threshold_high,
    output logic [EDGE_W-1:0] edge_count,
    output logic              frame_done
);

    // A frame cannot hold more edges than pixels, so the counter is sized to the
    // image, capped at the 17-bit output width (which sets the saturation point).
    localparam int PIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = ($clog2(PIX + 1) > EDGE_W) ? EDGE_W : $clog2(PIX + 1);

    state_t            state;
    logic              vsync_prev;
    logic              boundary, count_en, cnt_clear;
    logic [CNT_W-1:0]  edge_cnt, closing_total;

    logic [7:0]        sh_high, sh_low;
    logic [15:0]       sh_target;
    logic [3:0]        sh_step;
    logic              sh_auto;

    logic [16:0]       tgt17, margin, hi_bound, lo_bound;
    logic [8:0]        up_sum;
    logic [7:0]        high_up, high_dn, nxt_high, nxt_low;

    assign boundary  = vsync_prev & ~vsync;
    assign count_en  = (state == ST_RUN) && canny_ready && (canny_pixel == 8'hFF);
    assign cnt_clear = (state == ST_RUN) && boundary;

    canny_edge_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (count_en),
        .count (edge_cnt)
    );

    // The counter clears on the boundary, so fold that cycle's edge in here.
    assign closing_total = (count_en && edge_cnt != '1) ? edge_cnt + CNT_W'(1) : edge_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_high   <= 8'(TH_HIGH_INIT);
            sh_low    <= 8'(TH_LOW_INIT);
            sh_target <= 16'(TARGET_INIT);
            sh_step   <= 4'(STEP_INIT);
            sh_auto   <= 1'b0;
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_THRESH: {sh_high, sh_low} <= cfg_wdata;
                CFG_TARGET: sh_target <= cfg_wdata;
                CFG_AUTO: begin
                    sh_step <= cfg_wdata[3:0];
                    sh_auto <= cfg_wdata[8];
                end
                CFG_RSVD: ;
                default: ;
            endcase
        end
    end

    assign tgt17    = {1'b0, sh_target};
    assign margin   = tgt17 >> 3;
    assign hi_bound = tgt17 + margin;
    assign lo_bound = (tgt17 > margin) ? tgt17 - margin : '0;
    assign up_sum   = {1'b0, threshold_high} + {5'b0, sh_step};
    assign high_up  = up_sum[8] ? 8'hFF : up_sum[7:0];
    assign high_dn  = ({1'b0, threshold_high} >= {5'b0, sh_step} + 9'(TH_MIN))
                    ? threshold_high - {4'b0, sh_step} : 8'(TH_MIN);

    always_comb begin
        nxt_high = threshold_high;
        nxt_low  = threshold_low;
        if (sh_auto) begin
            if (sh_step != 4'd0) begin
                if (edge_count > hi_bound)
                    nxt_high = high_up;
                else if (edge_count < lo_bound)
                    nxt_high = high_dn;
                nxt_low = nxt_high >> 1;
            end
        end else begin
            nxt_high = sh_high;
            nxt_low  = (sh_low > sh_high) ? sh_high : sh_low;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            vsync_prev     <= 1'b1;
            canny_enable   <= 1'b0;
            frame_done     <= 1'b0;
            edge_count     <= '0;
            threshold_high <= 8'(TH_HIGH_INIT);
            threshold_low  <= 8'(TH_LOW_INIT);
        end else begin
            vsync_prev <= vsync;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: if (boundary) begin
                    state        <= ST_RUN;
                    canny_enable <= 1'b1;
                end
                ST_RUN: if (boundary) begin
                    state      <= ST_UPDATE;
                    edge_count <= EDGE_W'(closing_total);
                end
                ST_UPDATE: begin
                    state          <= ST_RUN;
                    threshold_high <= nxt_high;
                    threshold_low  <= nxt_low;
                    frame_done     <= 1'b1;
                end
                default: begin
                    state        <= ST_IDLE;
                    canny_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_canny_threshold_ctrl.sv
// Directed bench for canny_threshold_ctrl: manual/auto threshold updates,
// boundary-cycle counting, clamps and mid-frame reset.
module tb_canny_threshold_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, vsync, canny_ready, cfg_we;
    logic [7:0]  canny_pixel;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        canny_enable, frame_done;
    logic [7:0]  threshold_low, threshold_high;
    logic [16:0] edge_count;

    int n_run = 0;
    int n_fail = 0;

    canny_threshold_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .vsync          (vsync),
        .canny_ready    (canny_ready),
        .canny_pixel    (canny_pixel),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .canny_enable   (canny_enable),
        .threshold_low  (threshold_low),
        .threshold_high (threshold_high),
        .edge_count     (edge_count),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic edges(input int n);
        canny_ready = 1'b1; canny_pixel = 8'hFF;
        repeat (n) tick();
        canny_ready = 1'b0; canny_pixel = 8'h00;
    endtask

    // Drops vsync for one cycle; returns at T+1 with vsync back high.
    task automatic bnd(input bit edge_on_bnd);
        vsync = 1'b0;
        canny_ready = edge_on_bnd; canny_pixel = edge_on_bnd ? 8'hFF : 8'h00;
        tick();
        vsync = 1'b1; canny_ready = 1'b0; canny_pixel = 8'h00;
    endtask

    task automatic thr(input string tag, input int hi, input int lo);
        chk({tag, "_hi"}, 32'(threshold_high), 32'(hi));
        chk({tag, "_lo"}, 32'(threshold_low), 32'(lo));
    endtask

    // Closes a frame: checks total at T+1, thresholds and single frame_done pulse.
    task automatic close_frame(input string tag, input int cnt, input int hi, input int lo);
        bnd(1'b0);
        chk({tag, "_cnt"}, 32'(edge_count), 32'(cnt));
        chk({tag, "_fd_t1"}, 32'(frame_done), 0);
        tick();
        thr(tag, hi, lo);
        chk({tag, "_fd_t2"}, 32'(frame_done), 1);
        tick();
        chk({tag, "_fd_t3"}, 32'(frame_done), 0);
    endtask

    initial begin
        rst_n = 1'b0; vsync = 1'b1; canny_ready = 1'b0; canny_pixel = 8'h00;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'h0;
        repeat (3) tick();
        chk("rst_en", 32'(canny_enable), 0);
        chk("rst_fd", 32'(frame_done), 0);
        chk("rst_cnt", 32'(edge_count), 0);
        thr("rst", 100, 50);
        rst_n = 1'b1;

        // No boundary: stays disabled, pixels ignored
        edges(5);
        repeat (20) tick();
        chk("idle_en", 32'(canny_enable), 0);
        thr("idle", 100, 50);

        bnd(1'b0);
        chk("run_en", 32'(canny_enable), 1);
        chk("run_fd", 32'(frame_done), 0);
        tick();

        // Manual write mid-frame; non-edge pixel patterns must not count
        edges(6);
        canny_ready = 1'b1; canny_pixel = 8'h00; repeat (4) tick();
        canny_ready = 1'b0; canny_pixel = 8'hFF; repeat (4) tick();
        canny_pixel = 8'h00;
        cfg_wr(2'd0, 16'h7828);
        edges(4);
        thr("man_hold", 100, 50);
        close_frame("man", 10, 120, 40);

        // low > high clamps to high; edge on the boundary cycle goes in the closing frame
        cfg_wr(2'd0, 16'h3050);
        edges(5);
        bnd(1'b1);
        chk("bnd_cnt", 32'(edge_count), 6);
        tick();
        thr("clamp", 48, 48);
        cfg_wr(2'd0, 16'h6432);
        edges(3);
        close_frame("newfrm", 3, 100, 50);

        // Auto mode, target 4000 (window 3500..4500), step 4
        cfg_wr(2'd1, 16'd4000);
        cfg_wr(2'd2, 16'h0104);
        edges(5000);
        close_frame("auto5000", 5000, 104, 52);
        edges(3600);
        close_frame("auto3600", 3600, 104, 52);
        edges(4500);
        close_frame("auto4500", 4500, 104, 52);
        edges(4501);
        close_frame("auto4501", 4501, 108, 54);
        edges(3500);
        close_frame("auto3500", 3500, 108, 54);
        edges(3499);
        close_frame("auto3499", 3499, 104, 52);
        cfg_wr(2'd2, 16'h0100);
        close_frame("step0", 0, 104, 52);

        // TH_MIN floor
        cfg_wr(2'd2, 16'h0004);
        cfg_wr(2'd0, 16'h1209);
        close_frame("man18", 0, 18, 9);
        cfg_wr(2'd2, 16'h0104);
        close_frame("floor1", 0, 16, 8);
        close_frame("floor2", 0, 16, 8);

        // 255 ceiling with target 0 (window 0..0); addr3 writes have no effect
        cfg_wr(2'd2, 16'h0004);
        cfg_wr(2'd0, 16'hFD10);
        close_frame("man253", 0, 253, 16);
        cfg_wr(2'd1, 16'd0);
        cfg_wr(2'd2, 16'h0104);
        edges(1);
        close_frame("ceil", 1, 255, 127);
        cfg_wr(2'd3, 16'hFFFF);
        close_frame("rsvd", 0, 255, 127);

        // Asynchronous reset mid-frame after 300 edges
        edges(300);
        rst_n = 1'b0;
        #2;
        chk("arst_en", 32'(canny_enable), 0);
        chk("arst_cnt", 32'(edge_count), 0);
        chk("arst_fd", 32'(frame_done), 0);
        thr("arst", 100, 50);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        edges(4);
        repeat (5) tick();
        chk("arst_idle_en", 32'(canny_enable), 0);
        bnd(1'b0);
        chk("arst_run_en", 32'(canny_enable), 1);
        tick();
        edges(7);
        close_frame("arst_frm", 7, 100, 50);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/canny_threshold_ctrl.md
CANNY_THRESHOLD_CTRL -- requirements
Module: canny_threshold_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320, active pixels per line, used only to size the edge counter.
REQ-002 SHALL have parameter IMG_HEIGHT, default 240, active lines per frame, used only to size the edge counter.
REQ-003 SHALL have parameter TH_HIGH_INIT, default 100, reset and manual-default high threshold.
REQ-004 SHALL have parameter TH_LOW_INIT, default 50, reset and manual-default low threshold.
REQ-005 SHALL have parameter TH_MIN, default 16, floor for the auto high threshold.
REQ-006 SHALL have parameter TARGET_INIT, default 4000, reset target edge count per frame.
REQ-007 SHALL have parameter STEP_INIT, default 4, reset auto adjustment step.
REQ-008 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-009 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port vsync, input, 1, frame sync; its falling edge is the frame boundary.
REQ-011 SHALL have port canny_ready, input, 1, valid strobe from the edge detector.
REQ-012 SHALL have port canny_pixel, input, 8, detector output pixel (0x00 or 0xFF).
REQ-013 SHALL have port cfg_we, input, 1, config write strobe (single cycle).
REQ-014 SHALL have port cfg_addr, input, 2, config register select.
REQ-015 SHALL have port cfg_wdata, input, 16, config write data.
REQ-016 SHALL have port canny_enable, output, 1, drives the detector enable.
REQ-017 SHALL have port threshold_low, output, 8, active low threshold.
REQ-018 SHALL have port threshold_high, output, 8, active high threshold.
REQ-019 SHALL have port edge_count, output, 17, edge-pixel total of the last completed frame.
REQ-020 SHALL have port frame_done, output, 1, one-cycle pulse when new thresholds take effect.

Function
REQ-021 SHALL detect the frame boundary as vsync_prev & ~vsync, where vsync_prev resets to 1.
REQ-022 SHALL define the config registers as follows:
- addr0 {high[15:8], low[7:0]}: manual thresholds.
- addr1 [15:0]: target edge count.
- addr2 [3:0]: step.
- addr2 [8]: auto mode.
- addr3: writes are ignored.
REQ-023 SHALL hold config writes in shadow registers only; outputs change only in the UPDATE state.
REQ-024 SHALL implement the FSM as follows:
- IDLE → RUN on the first frame boundary.
- RUN → UPDATE on a frame boundary.
- UPDATE → RUN unconditionally after 1 cycle.
REQ-025 SHALL drive canny_enable to 0 in IDLE and to 1 in RUN and UPDATE.
REQ-026 SHALL count cycles with canny_ready=1 and canny_pixel=0xFF in RUN, saturating at 0x1FFFF.
REQ-027 SHALL include an edge counted on the boundary cycle in the closing frame's total.
REQ-028 SHALL meet the following timing for a boundary at cycle T:
- At T+1: the FSM is in UPDATE and edge_count holds the closing total; the running counter clears to 0.
- At T+2: threshold_high/threshold_low are updated and frame_done is 1 for exactly one cycle.
REQ-029 SHALL in auto mode use margin = target>>3 and adjust high as follows:
- edge_count > target+margin: high = min(high+step, 255).
- edge_count < target−margin: high = max(high−step, TH_MIN).
- otherwise: high unchanged.
REQ-030 SHALL in auto mode set low = high>>1, where high is the updated value.
REQ-031 SHALL in manual mode load high/low from the addr0 shadow, with low clamped to high if low > high.
REQ-032 SHALL compute target+margin in 17 bits so that it cannot overflow; the subtraction SHALL floor at 0.
REQ-033 SHALL, when cfg_we coincides with a boundary, write the shadow first, so that UPDATE uses the new value.
REQ-034 SHALL treat step=0 as "hold thresholds" in auto mode.

Reset
REQ-035 SHALL, while rst_n=0 and asynchronously, set the following:
- FSM=IDLE.
- canny_enable=0, frame_done=0, edge_count=0, counter=0.
- threshold_high=TH_HIGH_INIT, threshold_low=TH_LOW_INIT.
- shadow registers to INIT parameters, with auto mode=0.
REQ-036 SHALL, on reset asserted mid-frame, discard the partial count; after release, wait in IDLE for the next boundary.

Structure
REQ-037 SHALL place the FSM state encoding, cfg address constants and INIT defaults in shared package canny_pkg.
REQ-038 SHALL implement the saturating edge counter as sub-module canny_edge_counter (clear, inc, count).

Verification
REQ-039 SHALL cover: after reset with no vsync edge → canny_enable=0 and thresholds 100/50 indefinitely.
REQ-040 SHALL cover: manual write addr0=0x7828 mid-frame → outputs stay 100/50 until T+2, then read 120/40, with frame_done pulsed once.
REQ-041 SHALL cover: auto mode with target 4000, step 4, and 5000 edges in a frame → high 100→104 and low 52 at T+2; with 3600 edges → high unchanged.
REQ-042 SHALL cover: auto mode with high=18, step 4, and 0 edges → high=16 (TH_MIN) and low=8; repeated frames keep 16.
REQ-043 SHALL cover: canny_ready with pixel 0xFF asserted on the boundary cycle → counted in the closing frame; the new frame counter starts at 0.
REQ-044 SHALL cover: rst_n pulsed low mid-frame after 300 edges → immediate reset values; the next edge_count excludes those 300.
